seg7_scan_driver: RTL

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_decode.sv | 16 +
 rtl/seg7_scan_driver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the multiplexed 7-segment scan driver.
//   state_t    : scan FSM states (BLANK gap / DWELL on a digit)
//   SEG_OFF    : active-high all-segments-off pattern
//   SEG_TABLE  : hex nibble -> {a,b,c,d,e,f,g}, active-high, a = MSB
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'b000_0000;

    // Entry 15 first so that SEG_TABLE[n] is the pattern for nibble n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b100_0111,  // F
        7'b100_1111,  // E
        7'b011_1101,  // d
        7'b100_1110,  // C
        7'b001_1111,  // b
        7'b111_0111,  // A
        7'b111_1011,  // 9
        7'b111_1111,  // 8
        7'b111_0000,  // 7
        7'b101_1111,  // 6
        7'b101_1011,  // 5
        7'b011_0011,  // 4
        7'b111_1001,  // 3
        7'b110_1101,  // 2
        7'b011_0000,  // 1
        7'b111_1110   // 0
    };

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational hex nibble to 7-segment decoder (active-high).
//   i_nib : input  4  hex digit
//   o_seg : output 7  segments {a,b,c,d,e,f,g}, a = MSB
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-segment digits.
// Each digit gets a REFRESH_DIV-cycle period: BLANK_CYC all-off cycles followed
// by a dwell with its anode on. Displayed data comes from a shadow register
// captured on `load`; a digit's pattern is frozen at the start of its dwell.
//
// Ports
//   clk        in   1             rising-edge clock
//   rst        in   1             asynchronous active-high reset
//   digits_in  in   4*NUM_DIGITS  hex nibbles, nibble 0 = rightmost digit
//   dp_in      in   NUM_DIGITS    decimal point per digit
//   load       in   1             capture digits_in/dp_in into shadow
//   en         in   1             0 forces all anodes/segments off
//   seg        out  7             {a..g}, a = MSB
//   dp         out  1             decimal point of active digit
//   an         out  NUM_DIGITS    one-hot digit enable
//   frame_tick out  1             pulse on the cycle the digit index wraps to 0
//
// Build option: define SEG7_LZB_EN for leading-zero blanking (digit 0 is
// always shown, dp unaffected). Default build decodes every digit.
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 2,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t                     r_state;
    logic [CW-1:0]              r_cnt;
    logic [IW-1:0]              r_idx;
    logic [NUM_DIGITS-1:0][3:0] r_shadow;
    logic [NUM_DIGITS-1:0]      r_shadow_dp;
    logic [6:0]                 r_pat;
    logic                       r_pat_dp;
    logic [6:0]                 r_seg;
    logic                       r_dp;
    logic [NUM_DIGITS-1:0]      r_an;
    logic                       r_tick;

    logic                       w_last;
    logic                       w_wrap;
    logic                       w_enter;
    logic [CW-1:0]              w_cnt_nxt;
    logic [IW-1:0]              w_idx_nxt;
    state_t                     w_state_nxt;
    logic [NUM_DIGITS-1:0][3:0] w_src;
    logic [NUM_DIGITS-1:0]      w_src_dp;
    logic [NUM_DIGITS-1:0]      w_lzb;
    logic [3:0]                 w_nib;
    logic [6:0]                 w_seg_raw;
    logic [6:0]                 w_seg_new;
    logic                       w_dp_new;

    // The counter position within the digit period fully determines the phase:
    // [0, BLANK_CYC) is the gap, the rest is the dwell. With BLANK_CYC = 0 the
    // dwell phase covers the whole period, so DWELL follows DWELL directly.
    always_comb begin
        w_last    = (r_cnt == CW'(REFRESH_DIV - 1));
        w_cnt_nxt = w_last ? '0 : r_cnt + CW'(1);
        w_wrap    = w_last && (r_idx == IW'(NUM_DIGITS - 1));
        if (w_wrap)
            w_idx_nxt = '0;
        else if (w_last)
            w_idx_nxt = r_idx + IW'(1);
        else
            w_idx_nxt = r_idx;
        w_state_nxt = (w_cnt_nxt >= CW'(BLANK_CYC)) ? ST_DWELL : ST_BLANK;
        // A new dwell begins either out of BLANK or back-to-back at a period end.
        w_enter     = (w_state_nxt == ST_DWELL) && ((r_state == ST_BLANK) || w_last);
    end

    // Bypass the shadow when load lands on the edge a dwell starts, so data
    // captured at a frame wrap reaches digit 0 even without a blank gap.
    assign w_src    = load ? digits_in : r_shadow;
    assign w_src_dp = load ? dp_in     : r_shadow_dp;

`ifdef SEG7_LZB_EN
    // Blank every zero nibble above the most significant non-zero one.
    always_comb begin : lzb_scan
        logic seen;
        seen  = 1'b0;
        w_lzb = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen     = seen | (w_src[i] != 4'h0);
            w_lzb[i] = ~seen;
        end
    end
`else
    assign w_lzb = '0;
`endif

    assign w_nib = w_src[w_idx_nxt];

    seg7_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg_raw)
    );

    assign w_seg_new = w_lzb[w_idx_nxt] ? SEG_OFF : w_seg_raw;
    assign w_dp_new  = w_src_dp[w_idx_nxt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_BLANK;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_pat       <= SEG_OFF;
            r_pat_dp    <= 1'b0;
            r_seg       <= SEG_OFF;
            r_dp        <= 1'b0;
            r_an        <= '0;
            r_tick      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_tick  <= w_wrap;
            if (load) begin
                r_shadow    <= digits_in;
                r_shadow_dp <= dp_in;
            end
            // Pattern frozen for the whole dwell; survives en toggling.
            if (w_enter) begin
                r_pat    <= w_seg_new;
                r_pat_dp <= w_dp_new;
            end
            // an/seg/dp all registered here so they switch on the same edge.
            if (en && (w_state_nxt == ST_DWELL)) begin
                r_an  <= NUM_DIGITS'(1) << w_idx_nxt;
                r_seg <= w_enter ? w_seg_new : r_pat;
                r_dp  <= w_enter ? w_dp_new  : r_pat_dp;
            end else begin
                r_an  <= '0;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b0;
            end
        end
    end

    assign an         = (ACTIVE_LOW != 0) ? ~r_an  : r_an;
    assign seg        = (ACTIVE_LOW != 0) ? ~r_seg : r_seg;
    assign dp         = (ACTIVE_LOW != 0) ? ~r_dp  : r_dp;
    assign frame_tick = r_tick;

endmodule
